// File: rtl/mw_pkg.sv
// Shared encodings for the microwave cooking sequencer.
// State codes are visible on the debug/display port, so their values are fixed.
package mw_pkg;

  localparam int STATE_W      = 3;
  localparam int MAX_TIME_DEF = 3599;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_READY   = 3'd1,
    ST_COOKING = 3'd2,
    ST_PAUSED  = 3'd3,
    ST_DONE    = 3'd4
  } mw_state_t;

  // The one-second prescaler only runs while the countdown or the beep timer needs it.
  function automatic logic counts_ticks(input mw_state_t s);
    return (s == ST_COOKING) || (s == ST_DONE);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// One-second tick generator: tick is a 1-cycle pulse on the last count of each TICK_DIV period.
// Latency: first tick TICK_DIV cycles after counting starts from a cleared counter; no backpressure.
module tick_prescaler #(
  parameter int TICK_DIV = 50000000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = en & ~clr & (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/microwave_controller.sv
// Cooking sequencer: load/start/pause/cancel, one-second countdown and a timed done beep.
// Countdown steps TICK_DIV cycles after COOKING entry; magnetron/lamp gating is combinational.
module microwave_controller
  import mw_pkg::*;
#(
  parameter int TICK_DIV = 50000000,
  parameter int TIME_W   = 12,
  parameter int MAX_TIME = MAX_TIME_DEF,
  parameter int BEEP_SEC = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              door_open,
  input  logic              start,
  input  logic              stop,
  input  logic              load,
  input  logic [TIME_W-1:0] time_in,
  output logic [TIME_W-1:0] remaining,
  output logic              magnetron_on,
  output logic              lamp_on,
  output logic              done_beep,
  output logic [STATE_W-1:0] state
);

  localparam logic [TIME_W-1:0] MAX_T  = TIME_W'(MAX_TIME);
  localparam logic [TIME_W-1:0] ONE_T  = TIME_W'(1);
  localparam int                BEEP_W = (BEEP_SEC > 1) ? $clog2(BEEP_SEC) : 1;
  localparam logic [BEEP_W-1:0] BEEP_LAST = BEEP_W'(BEEP_SEC - 1);

  mw_state_t         state_q;
  logic [BEEP_W-1:0] beep_cnt;
  logic [TIME_W-1:0] load_val;
  logic              tick;
  logic              presc_en;
  logic              is_cooking;
  logic              door_closed;

  assign load_val   = (time_in > MAX_T) ? MAX_T : time_in;
  assign presc_en   = counts_ticks(state_q);
  assign is_cooking = (state_q == ST_COOKING);
  assign state      = state_q;

  // Holding the prescaler clear outside COOKING/DONE covers every entry into a counting
  // state; the COOKING->DONE hand-off happens on a tick, where the counter wraps anyway.
  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (presc_en),
    .clr  (~presc_en),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      remaining <= '0;
      beep_cnt  <= '0;
      done_beep <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (load) begin
            remaining <= load_val;
            state_q   <= (load_val != '0) ? ST_READY : ST_IDLE;
          end
        end

        ST_READY: begin
          if (stop) begin
            state_q   <= ST_IDLE;
            remaining <= '0;
          end else if (load) begin
            remaining <= load_val;
            state_q   <= (load_val != '0) ? ST_READY : ST_IDLE;
          end else if (start && !door_open) begin
            state_q <= ST_COOKING;
          end
        end

        ST_COOKING: begin
          if (stop || door_open) begin
            state_q <= ST_PAUSED;
          end else if (tick) begin
            // A zero count here is unreachable in normal use; treat it as finished.
            if (remaining <= ONE_T) begin
              remaining <= '0;
              state_q   <= ST_DONE;
              beep_cnt  <= '0;
              done_beep <= 1'b1;
            end else begin
              remaining <= remaining - ONE_T;
            end
          end
        end

        ST_PAUSED: begin
          if (stop) begin
            state_q   <= ST_IDLE;
            remaining <= '0;
          end else if (start && !door_open) begin
            state_q <= ST_COOKING;
          end
        end

        ST_DONE: begin
          if (stop || door_open) begin
            state_q   <= ST_IDLE;
            remaining <= '0;
            done_beep <= 1'b0;
          end else if (load) begin
            remaining <= load_val;
            state_q   <= (load_val != '0) ? ST_READY : ST_IDLE;
            done_beep <= 1'b0;
          end else if (tick) begin
            if (beep_cnt == BEEP_LAST) begin
              state_q   <= ST_IDLE;
              beep_cnt  <= '0;
              done_beep <= 1'b0;
            end else begin
              beep_cnt <= beep_cnt + 1'b1;
            end
          end
        end

        default: begin
          state_q   <= ST_IDLE;
          remaining <= '0;
          beep_cnt  <= '0;
          done_beep <= 1'b0;
        end
      endcase
    end
  end

  // The magnetron follows the door switch directly so an opening door cuts power the same cycle.
  not u_door_n   (door_closed, door_open);
  and u_mag_gate (magnetron_on, is_cooking, door_closed);
  or  u_lamp     (lamp_on, door_open, is_cooking);

endmodule

// File: tb/tb_microwave_controller.sv
// Directed scenarios plus a randomized run against a rule-level model of the cooking sequencer.
module tb_microwave_controller;

  localparam int TICK_DIV = 4;
  localparam int TIME_W   = 12;
  localparam int MAX_TIME = 3599;
  localparam int BEEP_SEC = 3;

  localparam int M_IDLE = 0, M_READY = 1, M_COOK = 2, M_PAUSED = 3, M_DONE = 4;

  logic              clk = 1'b0;
  logic              rst, door_open, start, stop, load;
  logic [TIME_W-1:0] time_in;
  logic [TIME_W-1:0] remaining;
  logic              magnetron_on, lamp_on, done_beep;
  logic [2:0]        state;

  int errors = 0;
  int checks = 0;

  int m_state, m_rem, m_phase, m_beeps;

  always #5 clk = ~clk;

  microwave_controller #(
    .TICK_DIV (TICK_DIV),
    .TIME_W   (TIME_W),
    .MAX_TIME (MAX_TIME),
    .BEEP_SEC (BEEP_SEC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .door_open    (door_open),
    .start        (start),
    .stop         (stop),
    .load         (load),
    .time_in      (time_in),
    .remaining    (remaining),
    .magnetron_on (magnetron_on),
    .lamp_on      (lamp_on),
    .done_beep    (done_beep),
    .state        (state)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; door_open = 1'b0; start = 1'b0; stop = 1'b0; load = 1'b0; time_in = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic load_time(input logic [TIME_W-1:0] t);
    time_in = t; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; door_open = 1'b1; start = 1'b0; stop = 1'b0; load = 1'b0; time_in = '0;
    step();
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
    checks++; if (remaining !== 12'd0) begin errors++; $display("FAIL reset_remaining: got %0d want 0", remaining); end
    checks++; if (done_beep !== 1'b0) begin errors++; $display("FAIL reset_beep: got %b want 0", done_beep); end
    checks++; if (magnetron_on !== 1'b0) begin errors++; $display("FAIL reset_mag: got %b want 0", magnetron_on); end
    checks++; if (lamp_on !== 1'b1) begin errors++; $display("FAIL reset_lamp_door_open: got %b want 1", lamp_on); end
    door_open = 1'b0; #1;
    checks++; if (lamp_on !== 1'b0) begin errors++; $display("FAIL reset_lamp_door_closed: got %b want 0", lamp_on); end
    rst = 1'b0;
  endtask

  task automatic test_basic_cook();
    int exp_rem;
    do_reset();
    load_time(12'd3);
    checks++; if (state !== 3'd1 || remaining !== 12'd3) begin errors++; $display("FAIL basic_load: state=%0d rem=%0d want 1/3", state, remaining); end
    pulse_start();
    checks++; if (state !== 3'd2 || magnetron_on !== 1'b1) begin errors++; $display("FAIL basic_cooking: state=%0d mag=%b want 2/1", state, magnetron_on); end
    for (int k = 1; k <= 12; k++) begin
      step();
      exp_rem = 3 - k / TICK_DIV;
      checks++; if (remaining !== 12'(exp_rem)) begin errors++; $display("FAIL basic_countdown k=%0d: rem=%0d want %0d", k, remaining, exp_rem); end
    end
    checks++; if (state !== 3'd4 || done_beep !== 1'b1) begin errors++; $display("FAIL basic_done: state=%0d beep=%b want 4/1", state, done_beep); end
    for (int k = 1; k < 12; k++) begin
      step();
      checks++; if (state !== 3'd4 || done_beep !== 1'b1) begin errors++; $display("FAIL basic_beep_hold k=%0d: state=%0d beep=%b want 4/1", k, state, done_beep); end
    end
    step();
    checks++; if (state !== 3'd0 || done_beep !== 1'b0) begin errors++; $display("FAIL basic_beep_end: state=%0d beep=%b want 0/0", state, done_beep); end
  endtask

  task automatic test_door_interrupt();
    int exp_rem;
    do_reset();
    load_time(12'd5);
    pulse_start();
    for (int k = 1; k < 6; k++) step();
    checks++; if (remaining !== 12'd4) begin errors++; $display("FAIL door_pre_rem: rem=%0d want 4", remaining); end
    door_open = 1'b1; #1;
    checks++; if (magnetron_on !== 1'b0 || lamp_on !== 1'b1) begin errors++; $display("FAIL door_cutoff: mag=%b lamp=%b want 0/1", magnetron_on, lamp_on); end
    step();
    checks++; if (state !== 3'd3 || remaining !== 12'd4) begin errors++; $display("FAIL door_paused: state=%0d rem=%0d want 3/4", state, remaining); end
    for (int k = 0; k < 6; k++) step();
    checks++; if (state !== 3'd3 || remaining !== 12'd4) begin errors++; $display("FAIL door_hold: state=%0d rem=%0d want 3/4", state, remaining); end
    door_open = 1'b0;
    pulse_start();
    checks++; if (state !== 3'd2 || magnetron_on !== 1'b1) begin errors++; $display("FAIL door_resume: state=%0d mag=%b want 2/1", state, magnetron_on); end
    for (int k = 1; k <= 16; k++) begin
      step();
      exp_rem = 4 - k / TICK_DIV;
      checks++; if (remaining !== 12'(exp_rem)) begin errors++; $display("FAIL door_countdown k=%0d: rem=%0d want %0d", k, remaining, exp_rem); end
    end
    checks++; if (state !== 3'd4) begin errors++; $display("FAIL door_done: state=%0d want 4", state); end
  endtask

  task automatic test_stop();
    do_reset();
    load_time(12'd9);
    pulse_start();
    for (int k = 0; k < 5; k++) step();
    pulse_stop();
    checks++; if (state !== 3'd3 || remaining !== 12'd8) begin errors++; $display("FAIL stop_pause: state=%0d rem=%0d want 3/8", state, remaining); end
    for (int k = 0; k < 4; k++) step();
    checks++; if (remaining !== 12'd8 || magnetron_on !== 1'b0) begin errors++; $display("FAIL stop_hold: rem=%0d mag=%b want 8/0", remaining, magnetron_on); end
    pulse_stop();
    checks++; if (state !== 3'd0 || remaining !== 12'd0) begin errors++; $display("FAIL stop_cancel: state=%0d rem=%0d want 0/0", state, remaining); end
  endtask

  task automatic test_start_door_open();
    do_reset();
    load_time(12'd6);
    door_open = 1'b1;
    pulse_start();
    checks++; if (state !== 3'd1 || magnetron_on !== 1'b0 || lamp_on !== 1'b1) begin errors++; $display("FAIL start_door_open: state=%0d mag=%b lamp=%b want 1/0/1", state, magnetron_on, lamp_on); end
    door_open = 1'b0;
  endtask

  task automatic test_boundary();
    do_reset();
    load_time(12'd4000);
    checks++; if (state !== 3'd1 || remaining !== 12'd3599) begin errors++; $display("FAIL clamp_load: state=%0d rem=%0d want 1/3599", state, remaining); end
    load_time(12'd0);
    checks++; if (state !== 3'd0 || remaining !== 12'd0) begin errors++; $display("FAIL zero_load: state=%0d rem=%0d want 0/0", state, remaining); end
  endtask

  task automatic test_collisions();
    do_reset();
    load_time(12'd5);
    pulse_start();
    step();
    pulse_stop();
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    checks++; if (state !== 3'd0 || remaining !== 12'd0) begin errors++; $display("FAIL start_stop_paused: state=%0d rem=%0d want 0/0", state, remaining); end
    load_time(12'd1);
    pulse_start();
    for (int k = 0; k < 3; k++) step();
    door_open = 1'b1;
    step();
    checks++; if (state !== 3'd3 || remaining !== 12'd1) begin errors++; $display("FAIL door_vs_tick: state=%0d rem=%0d want 3/1", state, remaining); end
    door_open = 1'b0;
  endtask

  task automatic test_reset_mid_cook();
    do_reset();
    load_time(12'd10);
    pulse_start();
    for (int k = 0; k < 12; k++) step();
    checks++; if (remaining !== 12'd7 || magnetron_on !== 1'b1) begin errors++; $display("FAIL midcook_pre: rem=%0d mag=%b want 7/1", remaining, magnetron_on); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (state !== 3'd0 || remaining !== 12'd0 || magnetron_on !== 1'b0 || done_beep !== 1'b0) begin
      errors++; $display("FAIL midcook_reset: state=%0d rem=%0d mag=%b beep=%b want 0/0/0/0", state, remaining, magnetron_on, done_beep);
    end
  endtask

  // Reference: applies the cooking rules for one clock edge; a tick is the last cycle of each
  // TICK_DIV-cycle window counted from entry into COOKING or DONE.
  task automatic model_edge(input logic r, input logic s, input logic d, input logic l,
                            input logic st, input int t);
    int  nxt, nrem;
    bit  counting, tick;
    counting = (m_state == M_COOK) || (m_state == M_DONE);
    tick     = counting && (m_phase == TICK_DIV - 1);
    nxt  = m_state;
    nrem = m_rem;
    if (r) begin
      nxt = M_IDLE; nrem = 0; m_beeps = 0;
    end else begin
      case (m_state)
        M_IDLE:   if (l) begin nrem = (t > MAX_TIME) ? MAX_TIME : t; nxt = (nrem != 0) ? M_READY : M_IDLE; end
        M_READY: begin
          if (s) begin nxt = M_IDLE; nrem = 0; end
          else if (l) begin nrem = (t > MAX_TIME) ? MAX_TIME : t; nxt = (nrem != 0) ? M_READY : M_IDLE; end
          else if (st && !d) nxt = M_COOK;
        end
        M_COOK: begin
          if (s || d) nxt = M_PAUSED;
          else if (tick) begin
            nrem = (m_rem > 0) ? m_rem - 1 : 0;
            if (nrem == 0) nxt = M_DONE;
          end
        end
        M_PAUSED: begin
          if (s) begin nxt = M_IDLE; nrem = 0; end
          else if (st && !d) nxt = M_COOK;
        end
        M_DONE: begin
          if (s || d) begin nxt = M_IDLE; nrem = 0; end
          else if (l) begin nrem = (t > MAX_TIME) ? MAX_TIME : t; nxt = (nrem != 0) ? M_READY : M_IDLE; end
          else if (tick) begin
            m_beeps++;
            if (m_beeps >= BEEP_SEC) nxt = M_IDLE;
          end
        end
        default: begin nxt = M_IDLE; nrem = 0; end
      endcase
    end
    if (r || nxt != m_state) m_phase = 0;
    else if (counting) m_phase = (m_phase + 1) % TICK_DIV;
    else m_phase = 0;
    if (nxt == M_DONE && m_state != M_DONE) m_beeps = 0;
    m_state = nxt;
    m_rem   = nrem;
  endtask

  task automatic test_random();
    int  sel;
    bit  exp_mag, exp_lamp, exp_beep;
    do_reset();
    m_state = M_IDLE; m_rem = 0; m_phase = 0; m_beeps = 0;
    for (int c = 0; c < 1500; c++) begin
      rst   = ($urandom_range(0, 199) == 0);
      stop  = ($urandom_range(0, 29) == 0);
      start = ($urandom_range(0, 5) == 0);
      load  = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 24) == 0) door_open = ~door_open;
      sel = $urandom_range(0, 9);
      if (sel == 0)      time_in = '0;
      else if (sel == 1) time_in = 12'(3600 + $urandom_range(0, 495));
      else if (sel == 2) time_in = 12'd3599;
      else               time_in = 12'($urandom_range(1, 6));
      model_edge(rst, stop, door_open, load, start, int'(time_in));
      step();
      exp_mag  = (m_state == M_COOK) && !door_open;
      exp_lamp = door_open || (m_state == M_COOK);
      exp_beep = (m_state == M_DONE);
      checks++; if (state !== 3'(m_state)) begin errors++; $display("FAIL rand_state c=%0d: got %0d want %0d", c, state, m_state); end
      checks++; if (remaining !== 12'(m_rem)) begin errors++; $display("FAIL rand_rem c=%0d: got %0d want %0d", c, remaining, m_rem); end
      checks++; if (magnetron_on !== exp_mag) begin errors++; $display("FAIL rand_mag c=%0d: got %b want %b", c, magnetron_on, exp_mag); end
      checks++; if (lamp_on !== exp_lamp) begin errors++; $display("FAIL rand_lamp c=%0d: got %b want %b", c, lamp_on, exp_lamp); end
      checks++; if (done_beep !== exp_beep) begin errors++; $display("FAIL rand_beep c=%0d: got %b want %b", c, done_beep, exp_beep); end
    end
    rst = 1'b0; start = 1'b0; stop = 1'b0; load = 1'b0; door_open = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_cook();
    test_door_interrupt();
    test_stop();
    test_start_door_open();
    test_boundary();
    test_collisions();
    test_reset_mid_cook();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
